// File: rtl/floo_wormhole_credit_out.sv
// floo_wormhole_credit_out: credit-based output link stage that registers arbitrated flits and tracks wormhole state.
// Define FLOO_WORMHOLE_CREDIT_OUT_STATS_EN to add flit_cnt_o/pkt_cnt_o statistics counters.
package floo_wormhole_credit_out_pkg;
  typedef struct packed {
    logic       last;
    logic [3:0] dst;
  } hdr_t;
  typedef struct packed {
    hdr_t        hdr;
    logic [15:0] payload;
  } flit_t;
endpackage

module floo_wormhole_credit_out #(
  parameter int unsigned NumCredits = 4,
  parameter type flit_t = floo_wormhole_credit_out_pkg::flit_t,
  parameter int unsigned CntWidth = $clog2(NumCredits + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                valid_i,
  output logic                ready_o,
  input  flit_t               data_i,
  output logic                valid_o,
  output flit_t               data_o,
  input  logic                credit_i,
  output logic [CntWidth-1:0] credits_o,
  output logic                in_packet_o,
  output logic                error_o
`ifdef FLOO_WORMHOLE_CREDIT_OUT_STATS_EN
  ,
  output logic [31:0]         flit_cnt_o,
  output logic [31:0]         pkt_cnt_o
`endif
);
  typedef enum logic {IDLE, PKT} state_e;
  state_e r_state, w_state_d;
  logic [CntWidth-1:0] r_credits, w_credits_d;
  logic r_valid, r_error, w_send, w_full, w_overflow;
  flit_t r_data;
  // ready comes only from the registered count, so there is no valid->ready path
  assign ready_o = r_credits != '0;
  assign w_send = valid_i & ready_o;
  assign w_full = r_credits == CntWidth'(NumCredits);
  assign w_overflow = credit_i & ~w_send & w_full;
  assign w_credits_d = (w_send & ~credit_i) ? r_credits - 1'b1 :
                       (credit_i & ~w_send & ~w_full) ? r_credits + 1'b1 : r_credits;
  assign valid_o = r_valid;
  assign data_o = r_data;
  assign credits_o = r_credits;
  assign in_packet_o = r_state == PKT;
  assign error_o = r_error;

  always_comb begin
    w_state_d = r_state;
    if (w_send) w_state_d = data_i.hdr.last ? IDLE : PKT;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_credits <= CntWidth'(NumCredits);
      r_valid <= 1'b0;
      r_data <= '0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_credits <= w_credits_d;
      r_valid <= w_send;
      if (w_send) r_data <= data_i;
      if (w_overflow) r_error <= 1'b1;
    end
  end

`ifdef FLOO_WORMHOLE_CREDIT_OUT_STATS_EN
  logic [31:0] r_flit_cnt, r_pkt_cnt;
  assign flit_cnt_o = r_flit_cnt;
  assign pkt_cnt_o = r_pkt_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_flit_cnt <= '0;
      r_pkt_cnt <= '0;
    end else if (w_send) begin
      r_flit_cnt <= r_flit_cnt + 32'd1;
      if (data_i.hdr.last) r_pkt_cnt <= r_pkt_cnt + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !w_overflow)
    else $warning("credit returned while counter already full");
  // the arbiter lock keeps valid_i up for the whole packet unless we stall it
  a_pkt_contiguous: assert property (@(posedge clk_i) disable iff (!rst_ni) (r_state == PKT && ready_o) |-> valid_i)
    else $warning("valid_i dropped inside a packet");
`endif
endmodule

// File: tb/tb_floo_wormhole_credit_out.sv
// tb_floo_wormhole_credit_out: table-driven vectors plus a data scoreboard for floo_wormhole_credit_out.
module tb_floo_wormhole_credit_out;
  import floo_wormhole_credit_out_pkg::*;

  typedef struct {
    logic        v;
    logic        last;
    logic [15:0] pl;
    logic        cr;
    logic        ev;
    logic [2:0]  ec;
    logic        ep;
    logic        ee;
  } vec_t;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic valid_i = 1'b0;
  logic credit_i = 1'b0;
  flit_t data_i = '0;
  logic ready_o, valid_o, in_packet_o, error_o;
  flit_t data_o;
  logic [2:0] credits_o;
`ifdef FLOO_WORMHOLE_CREDIT_OUT_STATS_EN
  logic [31:0] flit_cnt_o, pkt_cnt_o;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int m_cred = 4;
  flit_t last_sent = '0;
  flit_t sb[$];
  vec_t vecs[$];

  floo_wormhole_credit_out #(.NumCredits(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
    .valid_o(valid_o), .data_o(data_o), .credit_i(credit_i), .credits_o(credits_o),
    .in_packet_o(in_packet_o), .error_o(error_o)
`ifdef FLOO_WORMHOLE_CREDIT_OUT_STATS_EN
    , .flit_cnt_o(flit_cnt_o), .pkt_cnt_o(pkt_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic v, last, input logic [15:0] pl, input logic cr,
                              input logic ev, input logic [2:0] ec, input logic ep, ee);
    vec_t x;
    x.v = v; x.last = last; x.pl = pl; x.cr = cr; x.ev = ev; x.ec = ec; x.ep = ep; x.ee = ee;
    vecs.push_back(x);
  endfunction

  // called at a negedge; drives one cycle, checks the outputs at the following negedge
  task automatic step(input vec_t x);
    flit_t f;
    f = '0;
    f.hdr.last = x.last;
    f.hdr.dst = x.pl[3:0];
    f.payload = x.pl;
    chk("ready_o", {31'd0, ready_o}, {31'd0, m_cred != 0});
    valid_i = x.v;
    data_i = f;
    credit_i = x.cr;
    if (x.v && m_cred != 0) sb.push_back(f);
    @(negedge clk_i);
    valid_i = 1'b0;
    credit_i = 1'b0;
    chk("valid_o", {31'd0, valid_o}, {31'd0, x.ev});
    if (valid_o) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard: valid_o with data %0h but nothing expected", data_o);
      end else begin
        last_sent = sb.pop_front();
        chk("data_o", 32'(data_o), 32'(last_sent));
      end
    end else chk("data_o_hold", 32'(data_o), 32'(last_sent));
    chk("credits_o", {29'd0, credits_o}, {29'd0, x.ec});
    chk("in_packet_o", {31'd0, in_packet_o}, {31'd0, x.ep});
    chk("error_o", {31'd0, error_o}, {31'd0, x.ee});
    m_cred = int'(x.ec);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    chk("rst_valid_o", {31'd0, valid_o}, 32'd0);
    chk("rst_data_o", 32'(data_o), 32'd0);
    chk("rst_credits_o", {29'd0, credits_o}, 32'd4);
    chk("rst_in_packet_o", {31'd0, in_packet_o}, 32'd0);
    chk("rst_error_o", {31'd0, error_o}, 32'd0);
    chk("rst_ready_o", {31'd0, ready_o}, 32'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    m_cred = 4;
    last_sent = '0;
    sb.delete();
  endtask

  initial begin
    // back-to-back singles drain credits, 5th flit waits for a credit
    for (int i = 0; i < 4; i++) add(1, 1, 16'hA000 + 16'(i), 0, 1, 3'(3 - i), 0, 0);
    add(1, 1, 16'hA004, 0, 0, 0, 0, 0);
    add(1, 1, 16'hA004, 1, 0, 1, 0, 0);
    add(1, 1, 16'hA004, 0, 1, 0, 0, 0);
    // 3-flit packet with only 2 credits stalls before the tail
    add(0, 0, 16'h0, 1, 0, 1, 0, 0);
    add(0, 0, 16'h0, 1, 0, 2, 0, 0);
    add(1, 0, 16'hB000, 0, 1, 1, 1, 0);
    add(1, 0, 16'hB001, 0, 1, 0, 1, 0);
    add(1, 1, 16'hB002, 0, 0, 0, 1, 0);
    add(1, 1, 16'hB002, 1, 0, 1, 1, 0);
    add(1, 1, 16'hB002, 0, 1, 0, 0, 0);
    // send and credit together keep the count steady
    add(0, 0, 16'h0, 1, 0, 1, 0, 0);
    add(0, 0, 16'h0, 1, 0, 2, 0, 0);
    for (int i = 0; i < 10; i++) add(1, 1, 16'hC000 + 16'(i), 1, 1, 2, 0, 0);
    // overflow at full count is sticky
    add(0, 0, 16'h0, 1, 0, 3, 0, 0);
    add(0, 0, 16'h0, 1, 0, 4, 0, 0);
    add(0, 0, 16'h0, 1, 0, 4, 0, 1);
    add(0, 0, 16'h0, 0, 0, 4, 0, 1);
    add(0, 0, 16'h0, 0, 0, 4, 0, 1);

    repeat (2) @(negedge clk_i);
    do_reset();
    foreach (vecs[i]) step(vecs[i]);

    do_reset();
    // send plus credit at full count is not an overflow
    add(1, 1, 16'hD000, 1, 1, 4, 0, 0);
    step(vecs[vecs.size() - 1]);
    // reset in the middle of a packet
    add(1, 0, 16'hE000, 0, 1, 3, 1, 0);
    step(vecs[vecs.size() - 1]);
    do_reset();
    chk("sb_empty", 32'(sb.size()), 32'd0);

`ifdef FLOO_WORMHOLE_CREDIT_OUT_STATS_EN
    chk("rst_flit_cnt_o", flit_cnt_o, 32'd0);
    chk("rst_pkt_cnt_o", pkt_cnt_o, 32'd0);
    begin
      int sizes[5] = '{1, 2, 3, 1, 4};
      int n = 0;
      foreach (sizes[p]) begin
        for (int k = 0; k < sizes[p]; k++) begin
          add(1, k == sizes[p] - 1, 16'hF000 + 16'(n), 1, 1, 4, k != sizes[p] - 1, 0);
          step(vecs[vecs.size() - 1]);
          n++;
        end
      end
    end
    chk("flit_cnt_o", flit_cnt_o, 32'd11);
    chk("pkt_cnt_o", pkt_cnt_o, 32'd5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
